// File: rtl/ula_seq.sv
// Multi-cycle ALU: one-cycle ADD/SUB/SLT/CMP, bit-serial MUL/DIV behind Start/Busy/Done.
// Define ULA_DIV_EN to build the restoring divider; otherwise op 101 is treated as reserved.
module ula_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Operacao,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] BusWires,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QHi,
    output logic             Busy,
    output logic             Done,
    output logic             Zero,
    output logic             Err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

    // Handshake: Start is sampled only in IDLE; Done pulses one cycle with Q/QHi/Zero/Err
    // valid in that same cycle; Busy is high only while an iterative op is running.
    state_t state, state_n;

    logic [WIDTH-1:0] acc_hi, acc_lo, opb;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic [WIDTH-1:0] sc_q, sc_qhi;
    logic             sc_err;
    logic             is_iter;
    logic             last_step;
`ifdef ULA_DIV_EN
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_fit;
`endif

    assign last_step = (cnt == CNT_W'(1));

    always_comb begin
        is_iter = (Operacao == 3'b100);
`ifdef ULA_DIV_EN
        if (Operacao == 3'b101 && BusWires != '0) is_iter = 1'b1;
`endif
    end

    always_comb begin
        sc_q   = '0;
        sc_qhi = '0;
        sc_err = 1'b0;
        case (Operacao)
            3'b000: sc_q = A + BusWires;
            3'b001: sc_q = A - BusWires;
            3'b010: sc_q[0] = (A < BusWires);
            3'b011: sc_q[0] = (A == BusWires);
`ifdef ULA_DIV_EN
            // Only reached with a zero divisor; non-zero divisors go iterative.
            3'b101: begin
                sc_q   = '1;
                sc_qhi = A;
                sc_err = 1'b1;
            end
`endif
            default: sc_err = 1'b1;
        endcase
    end

    // acc_hi:acc_lo is the partial product (MUL) or remainder:quotient-shifter (DIV).
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        it_hi   = mul_sum[WIDTH:1];
        it_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ULA_DIV_EN
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_fit  = (div_sh >= {1'b0, opb});
        div_diff = div_sh - {1'b0, opb};
        if (state == S_DIV) begin
            it_hi = div_fit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            it_lo = {acc_lo[WIDTH-2:0], div_fit};
        end
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:       if (Start && is_iter) state_n = (Operacao == 3'b100) ? S_MUL : S_DIV;
            S_MUL, S_DIV: if (last_step) state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state != S_IDLE);
        state_dbg = state;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            cnt    <= '0;
            Q      <= '0;
            QHi    <= '0;
            Done   <= 1'b0;
            Zero   <= 1'b0;
            Err    <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state == S_IDLE) begin
                if (Start) begin
                    if (is_iter) begin
                        acc_hi <= '0;
                        acc_lo <= A;
                        opb    <= BusWires;
                        cnt    <= CNT_W'(WIDTH);
                    end else begin
                        Q    <= sc_q;
                        QHi  <= sc_qhi;
                        Err  <= sc_err;
                        Zero <= (sc_q == '0);
                        Done <= 1'b1;
                    end
                end
            end else begin
                acc_hi <= it_hi;
                acc_lo <= it_lo;
                cnt    <= cnt - CNT_W'(1);
                if (last_step) begin
                    Q    <= it_lo;
                    QHi  <= it_hi;
                    Err  <= 1'b0;
                    Zero <= (it_lo == '0);
                    Done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: directed cases plus random ops, scoreboard fed by an arithmetic model.
module tb_ula_seq;
    localparam int W  = 16;
    localparam int EW = 2 * W + 2;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [2:0]    Operacao = '0;
    logic [W-1:0]  A = '0, BusWires = '0;
    logic [W-1:0]  Q, QHi;
    logic          Busy, Done, Zero, Err;
    logic [1:0]    state_dbg;

    logic [EW-1:0] exp_q[$];
    int            cyc_q[$];
    int            cyc = 0;
    int            n_chk = 0, n_pass = 0, n_seen = 0;
    logic          hold = 1'b0;

    ula_seq #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Operacao(Operacao),
        .A(A), .BusWires(BusWires), .Q(Q), .QHi(QHi), .Busy(Busy),
        .Done(Done), .Zero(Zero), .Err(Err), .state_dbg(state_dbg)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: returns {q, qhi, zero, err} and the Done latency in cycles after capture.
    function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, output int lat);
        logic [W-1:0]   q, qhi;
        logic [2*W-1:0] p;
        logic           err;
        q = '0; qhi = '0; err = 1'b0; lat = 0;
        case (op)
            3'd0: q = a + b;
            3'd1: q = a - b;
            3'd2: q = (a < b) ? W'(1) : W'(0);
            3'd3: q = (a == b) ? W'(1) : W'(0);
            3'd4: begin
                p = a * b;
                q = p[W-1:0];
                qhi = p[2*W-1:W];
                lat = W;
            end
`ifdef ULA_DIV_EN
            3'd5: begin
                if (b == 0) begin
                    q = '1; qhi = a; err = 1'b1;
                end else begin
                    q = a / b; qhi = a % b; lat = W;
                end
            end
`endif
            default: err = 1'b1;
        endcase
        return {q, qhi, (q == 0), err};
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation and its cycle.
    always @(negedge Clock) begin
        if (Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(Done), 64'(0));
            end else begin
                check("result", 64'({Q, QHi, Zero, Err}), 64'(exp_q.pop_front()));
                check("done_cycle", 64'(cyc), 64'(cyc_q.pop_front()));
            end
            n_seen++;
        end
    end

    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic hold_start);
        int lat;
        logic [EW-1:0] e;
        Start = 1'b1; Operacao = op; A = a; BusWires = b;
        e = model(op, a, b, lat);
        hold = hold_start && (lat > 0);
        @(posedge Clock);
        #1;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + lat);
        if (!hold) Start = 1'b0;
    endtask

    // Waits for the monitor to see Done; while busy, Busy must be high and any held
    // Start with scrambled operands must be ignored.
    task automatic wait_done();
        int seen0 = n_seen;
        for (int i = 0; i < W + 6; i++) begin
            @(negedge Clock);
            #2;
            if (n_seen != seen0) begin
                check("busy_in_done", 64'(Busy), 64'(0));
                return;
            end
            check("busy", 64'(Busy), 64'(1));
            if (hold) begin
                A = W'($urandom); BusWires = W'($urandom); Operacao = 3'($urandom_range(0, 7));
            end
        end
        check("done_timeout", 64'(0), 64'(1));
        exp_q.delete();
        cyc_q.delete();
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic hold_start);
        start_op(op, a, b, hold_start);
        wait_done();
    endtask

    initial begin
        repeat (2) @(negedge Clock);
        check("rst_q", 64'(Q), 64'(0));
        check("rst_flags", 64'({Busy, Done, Zero, Err, QHi}), 64'(0));
        Reset = 1'b0;
        @(negedge Clock);

        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0);
        run_op(3'd1, 16'd3, 16'd5, 1'b0);
        run_op(3'd2, 16'd3, 16'd5, 1'b0);
        run_op(3'd3, 16'd7, 16'd7, 1'b0);
        run_op(3'd4, 16'd300, 16'd300, 1'b1);
        run_op(3'd5, 16'd1000, 16'd7, 1'b1);
        run_op(3'd5, 16'd1000, 16'd0, 1'b0);
        run_op(3'd4, 16'd2, 16'd3, 1'b1);
        run_op(3'd0, 16'd4, 16'd4, 1'b0);
        run_op(3'd6, 16'd9, 16'd9, 1'b0);
        run_op(3'd7, 16'd0, 16'd0, 1'b0);

        // Reset in the middle of a multiply discards it.
        start_op(3'd4, 16'd1234, 16'd567, 1'b0);
        repeat (5) @(negedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_busy_done", 64'({Busy, Done}), 64'(0));
        check("midrst_q_qhi", 64'({Q, QHi}), 64'(0));
        check("midrst_zero_err", 64'({Zero, Err}), 64'(0));
        exp_q.delete();
        cyc_q.delete();
        @(negedge Clock);
        check("midrst_hold", 64'({Busy, Done, Q, QHi}), 64'(0));
        Reset = 1'b0;
        @(negedge Clock);
        run_op(3'd0, 16'd1, 16'd1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            run_op(op, a, b, 1'($urandom_range(0, 1)));
        end

        Start = 1'b0;
        hold  = 1'b0;
        repeat (4) @(negedge Clock);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
